// File: rtl/seq_detect_sched.sv
// Round-robin scheduler that shares one serial "10110" detector among NUM_REQ word requesters.
// A granted word clears the detector, is shifted in MSB-first, and its hit summary is returned tagged.
module seq_detect_sched #(
    parameter  int NUM_REQ = 4,
    parameter  int WORD_W  = 16,
    localparam int ID_W    = $clog2(NUM_REQ),
    localparam int CNT_W   = $clog2(WORD_W + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*WORD_W-1:0] req_data,
    output logic                      det_clear,
    output logic                      det_seq,
    output logic                      det_valid,
    input  logic                      det_detected,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [CNT_W-1:0]          rsp_count,
    output logic [CNT_W-1:0]          rsp_first_pos,
    output logic                      busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_SHIFT = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ID_W-1:0]     r_last;
    logic [ID_W-1:0]     r_id;
    logic [WORD_W-1:0]   r_shreg;
    logic [CNT_W-1:0]    r_bitidx;
    logic [CNT_W-1:0]    r_count;
    logic [CNT_W-1:0]    r_first;

    logic [NUM_REQ-1:0]  w_rot;
    logic                w_grant_vld;
    logic [ID_W-1:0]     w_grant_idx;
    logic [WORD_W-1:0]   w_grant_word;
    logic                w_accept;
    logic                w_last_bit;

    // Rotate the request vector so position 0 is the requester just after the last winner.
    always_comb begin
        w_rot       = NUM_REQ'({req_valid, req_valid} >> (int'(r_last) + 1));
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_grant_vld && w_rot[k]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = ID_W'((int'(r_last) + 1 + k) % NUM_REQ);
            end
        end
    end

    assign w_grant_word = req_data[int'(w_grant_idx)*WORD_W +: WORD_W];
    assign w_accept     = (r_state == S_IDLE) && w_grant_vld;
    assign w_last_bit   = (r_bitidx == CNT_W'(WORD_W - 1));

    always_comb begin
        req_ready = '0;
        if (w_accept) begin
            req_ready[w_grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_grant_vld) w_state_nxt = S_CLEAR;
            S_CLEAR: w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_last_bit) w_state_nxt = S_RESP;
            S_RESP:  if (rsp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last   <= ID_W'(NUM_REQ - 1);
            r_id     <= '0;
            r_shreg  <= '0;
            r_bitidx <= '0;
            r_count  <= '0;
            r_first  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_vld) begin
                        r_shreg <= w_grant_word;
                        r_id    <= w_grant_idx;
                        r_count <= '0;
                        r_first <= '0;
                    end
                end
                S_CLEAR: r_bitidx <= '0;
                S_SHIFT: begin
                    r_shreg  <= {r_shreg[WORD_W-2:0], 1'b0};
                    r_bitidx <= r_bitidx + CNT_W'(1);
                    if (det_detected) begin
                        r_count <= r_count + CNT_W'(1);
                        if (r_count == '0) r_first <= r_bitidx;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) r_last <= r_id;
                end
                default: ;
            endcase
        end
    end

    // Result fields are forced to zero outside RESP so reset leaves every output low.
    assign det_clear     = (r_state == S_CLEAR);
    assign det_valid     = (r_state == S_SHIFT);
    assign det_seq       = det_valid & r_shreg[WORD_W-1];
    assign rsp_valid     = (r_state == S_RESP);
    assign rsp_id        = rsp_valid ? r_id : '0;
    assign rsp_count     = rsp_valid ? r_count : '0;
    assign rsp_first_pos = !rsp_valid ? '0 : ((r_count == '0) ? CNT_W'(WORD_W) : r_first);
    assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_seq_detect_sched.sv
// Randomised scoreboard bench for seq_detect_sched with a behavioural "10110" detector attached.
module tb_seq_detect_sched;
    localparam int N     = 4;
    localparam int W     = 16;
    localparam int ID_W  = 2;
    localparam int CNT_W = 5;

    logic              clk;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*W-1:0]    req_data;
    logic              det_clear, det_seq, det_valid, det_detected;
    logic              rsp_valid, rsp_ready;
    logic [ID_W-1:0]   rsp_id;
    logic [CNT_W-1:0]  rsp_count, rsp_first_pos;
    logic              busy;

    seq_detect_sched #(.NUM_REQ(N), .WORD_W(W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .det_clear(det_clear), .det_seq(det_seq), .det_valid(det_valid),
        .det_detected(det_detected),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_count(rsp_count), .rsp_first_pos(rsp_first_pos), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Serial detector: remembers the bits seen since the last clear.
    logic [3:0] d_hist;
    int         d_n;
    always @(posedge clk) begin
        if (det_clear) begin
            d_hist <= '0;
            d_n    <= 0;
        end else if (det_valid) begin
            d_hist <= {d_hist[2:0], det_seq};
            d_n    <= (d_n < 8) ? d_n + 1 : d_n;
        end
    end
    assign det_detected = det_valid && (d_n >= 4) && ({d_hist, det_seq} == 5'b10110);

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic to_fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s timed out t=%0t", nm, $time);
    endtask

    // Reference: every 5-bit MSB-first window equal to 10110 is a hit, recorded at its last bit.
    function automatic void ref_scan(input logic [W-1:0] w, output int cnt, output int pos);
        cnt = 0;
        pos = W;
        for (int i = 4; i < W; i++) begin
            if (w[W+3-i -: 5] == 5'b10110) begin
                if (cnt == 0) pos = i;
                cnt++;
            end
        end
    endfunction

    typedef struct {
        int id;
        int cnt;
        int pos;
    } exp_t;

    exp_t          sb[$];
    int            grant_log[$];
    logic [N-1:0]  acc_seen = '0;
    int            n_rsp = 0;

    int            cyc = 0;
    bit            m_busy = 0;
    int            m_last = N - 1;
    int            m_t = 0;
    logic [W-1:0]  m_word = '0;
    bit            rst_prev = 1;
    bit            hold_prev = 0;
    int            p_id, p_cnt, p_pos;
    int            exp_g, e_cnt, e_pos;
    logic [N-1:0]  exp_rdy;
    bit            e_clr, e_dv, e_seq, e_rv;
    exp_t          e;

    always @(negedge clk) begin
        cyc++;
        if (rst_prev)
            chk("reset_outputs", int'({req_ready, det_clear, det_seq, det_valid, rsp_valid,
                                       rsp_id, rsp_count, rsp_first_pos, busy}), 0);
        e_clr = m_busy && (cyc == m_t + 1);
        e_dv  = m_busy && (cyc >= m_t + 2) && (cyc <= m_t + 1 + W);
        e_seq = e_dv ? m_word[W-1-(cyc-m_t-2)] : 1'b0;
        e_rv  = m_busy && (cyc >= m_t + 2 + W);
        chk("busy", busy, m_busy);
        chk("det_clear", det_clear, e_clr);
        chk("det_valid", det_valid, e_dv);
        chk("det_seq", det_seq, e_seq);
        chk("rsp_valid", rsp_valid, e_rv);

        exp_g = -1;
        if (!m_busy)
            for (int k = 1; k <= N; k++)
                if (exp_g < 0 && req_valid[(m_last + k) % N]) exp_g = (m_last + k) % N;
        exp_rdy = (exp_g >= 0) ? (N'(1) << exp_g) : '0;
        chk("req_ready", req_ready, exp_rdy);

        if (hold_prev && !rst_prev && rsp_valid) begin
            chk("stall_rsp_id", rsp_id, p_id);
            chk("stall_rsp_count", rsp_count, p_cnt);
            chk("stall_rsp_first_pos", rsp_first_pos, p_pos);
        end
        hold_prev = rsp_valid && !rsp_ready;
        p_id  = rsp_id;
        p_cnt = rsp_count;
        p_pos = rsp_first_pos;

        acc_seen = req_valid & req_ready;
        for (int i = 0; i < N; i++)
            if (acc_seen[i]) grant_log.push_back(i);

        if (e_rv && rsp_ready) begin
            if (sb.size() == 0) begin
                to_fail("scoreboard_empty");
            end else begin
                e = sb.pop_front();
                chk("rsp_id", rsp_id, e.id);
                chk("rsp_count", rsp_count, e.cnt);
                chk("rsp_first_pos", rsp_first_pos, e.pos);
                m_last = e.id;
            end
            m_busy = 0;
            n_rsp++;
        end else if (exp_g >= 0) begin
            m_busy = 1;
            m_t    = cyc;
            m_word = req_data[exp_g*W +: W];
            ref_scan(m_word, e_cnt, e_pos);
            e.id  = exp_g;
            e.cnt = e_cnt;
            e.pos = e_pos;
            sb.push_back(e);
        end
        if (reset) begin
            m_busy = 0;
            m_last = N - 1;
            sb.delete();
        end
        rst_prev = reset;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        req_valid = '0;
        tick();
        reset = 1'b0;
        tick();
    endtask

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] w;
        logic [4:0]   pat;
        int           ph;
        int           fl;
        pat = 5'b10110;
        w = W'($urandom);
        if ($urandom_range(0, 1) == 1) begin
            ph = $urandom_range(0, 4);
            for (int j = 0; j < W; j++) w[W-1-j] = pat[4-((j+ph)%5)];
            fl = $urandom_range(0, W - 1);
            w[fl] = ~w[fl];
        end
        return w;
    endfunction

    task automatic send_one(input int i, input logic [W-1:0] w);
        int base;
        bit got;
        base = n_rsp;
        got = 0;
        req_data[i*W +: W] = w;
        req_valid[i] = 1'b1;
        for (int k = 0; k < 50 && !got; k++) begin
            tick();
            if (acc_seen[i]) got = 1;
        end
        req_valid[i] = 1'b0;
        if (!got) to_fail("accept_wait");
        got = 0;
        for (int k = 0; k < W + 20 && !got; k++) begin
            tick();
            if (n_rsp > base) got = 1;
        end
        if (!got) to_fail("response_wait");
    endtask

    task automatic wait_idle(input string nm);
        bit got;
        got = 0;
        for (int k = 0; k < 4 * (W + 5) && !got; k++) begin
            tick();
            if (!busy && !m_busy) got = 1;
        end
        if (!got) to_fail(nm);
    endtask

    int rr_exp[5] = '{0, 1, 2, 3, 0};

    initial begin
        bit got;
        int base;
        reset = 1'b1;
        req_valid = '0;
        req_data = '0;
        rsp_ready = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        send_one(0, 16'hB000);
        send_one(0, 16'hB600);
        send_one(0, 16'h0000);
        reset_pulse();
        send_one(0, 16'hFFFF);
        send_one(3, 16'h5AD6);

        // All requesters persistently valid from reset.
        reset_pulse();
        grant_log.delete();
        base = n_rsp;
        for (int i = 0; i < N; i++) req_data[i*W +: W] = rand_word();
        req_valid = '1;
        got = 0;
        for (int k = 0; k < 6 * (W + 3) + 20 && !got; k++) begin
            tick();
            for (int i = 0; i < N; i++)
                if (acc_seen[i]) req_data[i*W +: W] = rand_word();
            if (n_rsp >= base + 5) got = 1;
        end
        req_valid = '0;
        if (!got || grant_log.size() < 5) to_fail("round_robin_wait");
        else for (int i = 0; i < 5; i++) chk("rr_grant_order", grant_log[i], rr_exp[i]);
        wait_idle("rr_drain");

        // Backpressure while other requesters wait.
        rsp_ready = 1'b0;
        req_data[1*W +: W] = 16'hB600;
        req_valid[1] = 1'b1;
        got = 0;
        for (int k = 0; k < 50 && !got; k++) begin
            tick();
            if (acc_seen[1]) got = 1;
        end
        if (!got) to_fail("bp_accept_wait");
        req_valid = 4'b1101;
        got = 0;
        for (int k = 0; k < W + 10 && !got; k++) begin
            tick();
            if (rsp_valid) got = 1;
        end
        if (!got) to_fail("bp_rsp_wait");
        repeat (10) tick();
        rsp_ready = 1'b1;
        got = 0;
        for (int k = 0; k < 10 && !got; k++) begin
            tick();
            if (|acc_seen) got = 1;
        end
        if (!got) to_fail("bp_regrant_wait");
        req_valid = '0;
        wait_idle("bp_drain");

        // Reset while bit index 7 is on the detector.
        req_data[2*W +: W] = 16'hB6B6;
        req_valid[2] = 1'b1;
        got = 0;
        for (int k = 0; k < 50 && !got; k++) begin
            tick();
            if (acc_seen[2]) got = 1;
        end
        req_valid = '0;
        if (!got) to_fail("midshift_accept_wait");
        repeat (8) tick();
        reset_pulse();
        grant_log.delete();
        for (int i = 0; i < N; i++) req_data[i*W +: W] = rand_word();
        req_valid = '1;
        got = 0;
        for (int k = 0; k < 10 && !got; k++) begin
            tick();
            if (|acc_seen) got = 1;
        end
        req_valid = '0;
        if (!got || grant_log.size() == 0) to_fail("post_reset_grant_wait");
        else chk("post_reset_grant", grant_log[0], 0);
        wait_idle("midshift_drain");

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (acc_seen[i]) begin
                    req_valid[i] = ($urandom_range(0, 1) == 1);
                    req_data[i*W +: W] = rand_word();
                end else if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    req_valid[i] = 1'b1;
                    req_data[i*W +: W] = rand_word();
                end else if (req_valid[i] && $urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        wait_idle("final_drain");
        chk("scoreboard_left", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seq_detect_sched.md
Name: seq_detect_sched

Overview:
- Scheduler that shares one serial "10110" sequence-detector datapath among NUM_REQ requesters.
- Each requester hands over a parallel WORD_W-bit word through a valid/ready handshake.
- The block arbitrates round-robin, clears the detector, then feeds the word MSB-first, one bit per cycle.
- It counts detections, records the first hit position, and returns a tagged result through a valid/ready response port.

Parameters:
- NUM_REQ, 4, number of requesters (≥2)
- WORD_W, 16, bits per request word (≥5)
- Derived localparams, not overridable:
  - ID_W = $clog2(NUM_REQ)
  - CNT_W = $clog2(WORD_W+1)

Ports:
- clk  in  1  clock, all logic rising-edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester word valid
- req_ready  out  NUM_REQ  per-requester accept, at most one bit high
- req_data  in  NUM_REQ*WORD_W  requester i word at bits [i*WORD_W +: WORD_W]
- det_clear  out  1  forces the detector to its idle state this cycle
- det_seq  out  1  serial bit to the detector
- det_valid  out  1  det_seq is meaningful
- det_detected  in  1  detector hit, combinational with det_seq, same cycle
- rsp_valid  out  1  result available
- rsp_ready  in  1  result consumer accept
- rsp_id  out  ID_W  requester index of the result
- rsp_count  out  CNT_W  number of detections in the word
- rsp_first_pos  out  CNT_W  bit index of the first hit (0 = MSB); WORD_W if none
- busy  out  1  high in any state other than IDLE

Behaviour:
- FSM states: IDLE, CLEAR, SHIFT, RESP.
- Reset:
  - State goes to IDLE; bit counter, count and first-position registers cleared.
  - Round-robin pointer last = NUM_REQ-1, so requester 0 has first priority.
  - All outputs 0 in the cycle after reset is sampled high.
  - A word in flight is discarded and no response is issued.
- IDLE:
  - Winner g = first i with req_valid[i], searching last+1, last+2, … modulo NUM_REQ.
  - req_ready[g] = 1 combinationally in this same cycle; all other req_ready bits are 0.
  - On accept: capture req_data slice g into the shift register and g into id_q, clear count/first, go to CLEAR.
  - req_ready is 0 in every other state.
- CLEAR (1 cycle):
  - det_clear = 1, det_valid = 0; go to SHIFT with bit index 0.
- SHIFT (exactly WORD_W cycles):
  - det_valid = 1, det_seq = shreg[WORD_W-1]; shreg shifts left by 1 each cycle.
  - If det_detected = 1 this cycle: count += 1; if count was 0, first = current bit index.
  - det_detected is ignored outside SHIFT.
  - After bit index WORD_W-1, go to RESP.
- RESP:
  - rsp_valid = 1; rsp_id/rsp_count/rsp_first_pos come from registers and stay stable until the handshake.
  - rsp_first_pos = WORD_W when count = 0.
  - On rsp_valid && rsp_ready: last = id_q, go to IDLE. rsp_valid drops the next cycle.
  - rsp_ready low stalls indefinitely; requests stay unaccepted meanwhile.
- Timing, for accept in cycle T:
  - det_clear in T+1.
  - Bits in T+2 … T+1+WORD_W.
  - rsp_valid first high in T+2+WORD_W.
  - Minimum spacing between accepts is WORD_W+3 cycles, with rsp_ready tied high.
- Counting:
  - count ≤ WORD_W by construction, so no saturation logic.
  - The detector's overlapping matches are each counted.
- Arbitration:
  - Requests may assert/deassert freely while not accepted; no fairness state changes without a grant.
  - Simultaneous requests are resolved purely by pointer order.
  - Round-robin guarantees each persistent requester is served within NUM_REQ words.
- Unused outputs: det_seq = 0 whenever det_valid = 0.

Test Plan:
- Single request, WORD_W=16: req_data[0]=0xB000 on requester 0 → req_ready[0] the same cycle; det_clear at T+1; bit stream 1,0,1,1,0,0…; rsp_id=0, rsp_count=1, rsp_first_pos=4, rsp_valid at T+18.
- Overlap: word 0xB600 (1011 0110 …) → rsp_count=2, rsp_first_pos=4.
- No match and reset: word 0x0000 → rsp_count=0, rsp_first_pos=16; then a second word 0xFFFF → count=0, pos=16.
- Round-robin: all four requesters valid continuously from reset → grant order 0,1,2,3,0; each rsp_id matches, and no requester is granted twice before the others are served.
- Backpressure: rsp_ready=0 for 10 cycles during RESP → rsp_* stable, all req_ready=0, busy=1; the grant follows in the cycle after rsp_ready=1 handshakes.
- Reset mid-SHIFT: reset asserted at bit index 7 → next cycle all outputs 0 and state IDLE; no response for the aborted word; the next grant goes to requester 0.
